// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the iterative CORDIC controller.
// Angles and coordinates are signed Q2.20.
package cordic_pkg;

    localparam int unsigned CORDIC_INT_WIDTH  = 2;
    localparam int unsigned CORDIC_FRAC_WIDTH = 20;
    localparam int unsigned CORDIC_DATA_WIDTH = CORDIC_INT_WIDTH + CORDIC_FRAC_WIDTH;
    localparam int unsigned CORDIC_CNT_WIDTH  = 4;
    localparam int unsigned CORDIC_ITERS      = 2 ** CORDIC_CNT_WIDTH;

    // 1/gain of the 16-step rotation, pre-applied to the starting x.
    localparam int K_INIT   = 636752;
    localparam int ATAN_SUM = 1827967;

    // round(atan(2^-k) * 2^20)
    localparam int ATAN [CORDIC_ITERS] = '{
        823550, 486170, 256879, 130396, 65451, 32757, 16383, 8192,
        4096,   2048,   1024,   512,    256,   128,   64,    32
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } cordic_state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the per-iteration rotation angle atan(2^-k).
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CORDIC_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = CORDIC_CNT_WIDTH
) (
    input  logic        [CNT_WIDTH-1:0]  k_i,
    output logic signed [DATA_WIDTH-1:0] angle_o
);

    always_comb begin
        angle_o = DATA_WIDTH'(ATAN[k_i]);
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequences 16 iterations of an external CORDIC stage, range-checks the target angle
// and captures cos/sin/achieved-angle once the last stage result is registered.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned INTEGER_WIDTH        = CORDIC_INT_WIDTH,
    parameter int unsigned DECIMAL_WIDTH        = CORDIC_FRAC_WIDTH,
    parameter int unsigned DATA_WIDTH           = INTEGER_WIDTH + DECIMAL_WIDTH,
    parameter int unsigned CORDIC_COUNTER_WIDTH = CORDIC_CNT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic signed [DATA_WIDTH-1:0]           target_in,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic signed [DATA_WIDTH-1:0]           result_x,
    output logic signed [DATA_WIDTH-1:0]           result_y,
    output logic signed [DATA_WIDTH-1:0]           result_angle,
    output logic                                   stage_en,
    output logic signed [DATA_WIDTH-1:0]           stage_target,
    output logic        [CORDIC_COUNTER_WIDTH-1:0] stage_shift_value,
    output logic signed [DATA_WIDTH-1:0]           stage_shift_angle,
    output logic signed [DATA_WIDTH-1:0]           stage_angle,
    output logic signed [DATA_WIDTH-1:0]           stage_x,
    output logic signed [DATA_WIDTH-1:0]           stage_y,
    input  logic signed [DATA_WIDTH-1:0]           stage_new_angle,
    input  logic signed [DATA_WIDTH-1:0]           stage_new_x,
    input  logic signed [DATA_WIDTH-1:0]           stage_new_y
);

    localparam logic signed [DATA_WIDTH-1:0] KInitW    = DATA_WIDTH'(K_INIT);
    localparam logic signed [DATA_WIDTH-1:0] MaxAngleW = DATA_WIDTH'(ATAN_SUM);
    localparam logic signed [DATA_WIDTH-1:0] MinAngleW = -MaxAngleW;

    cordic_state_e                    state_q, state_d;
    logic [CORDIC_COUNTER_WIDTH-1:0]  k_q, k_d;
    logic signed [DATA_WIDTH-1:0]     target_q, target_d;
    logic signed [DATA_WIDTH-1:0]     res_x_q, res_x_d;
    logic signed [DATA_WIDTH-1:0]     res_y_q, res_y_d;
    logic signed [DATA_WIDTH-1:0]     res_a_q, res_a_d;
    logic                             err_q, err_d;
    logic                             in_range;
    logic signed [DATA_WIDTH-1:0]     rom_angle;

    assign in_range = (target_in <= MaxAngleW) && (target_in >= MinAngleW);

    cordic_atan_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CORDIC_COUNTER_WIDTH)
    ) u_atan_rom (
        .k_i     (k_q),
        .angle_o (rom_angle)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        target_d = target_q;
        res_x_d  = res_x_q;
        res_y_d  = res_y_q;
        res_a_d  = res_a_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = !in_range;
                    if (in_range) begin
                        target_d = target_in;
                        k_d      = '0;
                        state_d  = StRun;
                    end else begin
                        res_x_d = '0;
                        res_y_d = '0;
                        res_a_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                // Counter wraps to zero on the last iteration.
                k_d = k_q + CORDIC_COUNTER_WIDTH'(1);
                if (k_q == '1) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                res_x_d = stage_new_x;
                res_y_d = stage_new_y;
                res_a_d = stage_new_angle;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            target_q <= '0;
            res_x_q  <= '0;
            res_y_q  <= '0;
            res_a_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            target_q <= target_d;
            res_x_q  <= res_x_d;
            res_y_q  <= res_y_d;
            res_a_q  <= res_a_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        busy              = (state_q == StRun) || (state_q == StDrain);
        done              = (state_q == StDone);
        stage_en          = (state_q == StRun);
        stage_target      = '0;
        stage_shift_value = '0;
        stage_shift_angle = '0;
        stage_x           = '0;
        stage_y           = '0;
        stage_angle       = '0;
        if (state_q == StRun) begin
            stage_target      = target_q;
            stage_shift_value = k_q;
            stage_shift_angle = rom_angle;
            // First iteration seeds the stage; later ones feed back its registered result.
            if (k_q == '0) begin
                stage_x = KInitW;
            end else begin
                stage_x     = stage_new_x;
                stage_y     = stage_new_y;
                stage_angle = stage_new_angle;
            end
        end
    end

    assign err          = err_q;
    assign result_x     = res_x_q;
    assign result_y     = res_y_q;
    assign result_angle = res_a_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Randomized bench for cordic_iter_ctrl: an in-bench CORDIC stage responder, a timeline
// reference model checked every cycle, and directed accuracy checks against cos/sin.
module tb_cordic_iter_ctrl;

    localparam int DW    = 22;
    localparam int CW    = 4;
    localparam int NIT   = 16;
    localparam int KINIT = 636752;
    localparam int ASUM  = 1827967;
    localparam int ONE   = 1048576;
    // Residual angle after 16 steps plus shift truncation.
    localparam int TOL   = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic signed [DW-1:0] target_in = '0;
    logic                 busy, done, err, stage_en;
    logic signed [DW-1:0] result_x, result_y, result_angle;
    logic signed [DW-1:0] stage_target, stage_shift_angle, stage_angle, stage_x, stage_y;
    logic        [CW-1:0] stage_shift_value;
    logic signed [DW-1:0] new_x = '0, new_y = '0, new_a = '0;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;
    int atan_ref [NIT];

    // Model: ph=0 idle, 1..16 run (k=ph-1), 17 drain, 18 done, -1 error done.
    int ph = 0;
    int m_tgt = 0;
    bit m_err = 1'b0;
    int m_rx = 0, m_ry = 0, m_ra = 0;

    always #5 clk = ~clk;

    cordic_iter_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .target_in         (target_in),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .result_x          (result_x),
        .result_y          (result_y),
        .result_angle      (result_angle),
        .stage_en          (stage_en),
        .stage_target      (stage_target),
        .stage_shift_value (stage_shift_value),
        .stage_shift_angle (stage_shift_angle),
        .stage_angle       (stage_angle),
        .stage_x           (stage_x),
        .stage_y           (stage_y),
        .stage_new_angle   (new_a),
        .stage_new_x       (new_x),
        .stage_new_y       (new_y)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        checks++;
        if (act > exp + TOL || act < exp - TOL) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, TOL);
        end
    endtask

    function automatic void cordic_ref(input int tgt, output int rx, output int ry,
                                       output int ra);
        int x = KINIT;
        int y = 0;
        int a = 0;
        int xn;
        for (int k = 0; k < NIT; k++) begin
            if (a < tgt) begin
                xn = x - (y >>> k);
                y  = y + (x >>> k);
                a  = a + atan_ref[k];
            end else begin
                xn = x + (y >>> k);
                y  = y - (x >>> k);
                a  = a - atan_ref[k];
            end
            x = xn;
        end
        rx = x;
        ry = y;
        ra = a;
    endfunction

    // External iterative stage: registered, one-cycle latency, zero when not enabled.
    always @(posedge clk) begin
        if (stage_en === 1'b1) begin
            if (stage_angle < stage_target) begin
                new_x <= stage_x - (stage_y >>> stage_shift_value);
                new_y <= stage_y + (stage_x >>> stage_shift_value);
                new_a <= stage_angle + stage_shift_angle;
            end else begin
                new_x <= stage_x + (stage_y >>> stage_shift_value);
                new_y <= stage_y - (stage_x >>> stage_shift_value);
                new_a <= stage_angle - stage_shift_angle;
            end
        end else begin
            new_x <= '0;
            new_y <= '0;
            new_a <= '0;
        end
    end

    always @(posedge clk) begin
        int t;
        t = target_in;
        if (reset) begin
            ph = 0; m_err = 1'b0; m_tgt = 0; m_rx = 0; m_ry = 0; m_ra = 0;
        end else if (ph == 0) begin
            if (start) begin
                if (t > ASUM || t < -ASUM) begin
                    ph = -1; m_err = 1'b1; m_rx = 0; m_ry = 0; m_ra = 0;
                end else begin
                    ph = 1; m_err = 1'b0; m_tgt = t;
                end
            end
        end else if (ph == -1 || ph == 18) begin
            ph = 0;
        end else begin
            ph++;
            if (ph == 18) cordic_ref(m_tgt, m_rx, m_ry, m_ra);
        end
    end

    always @(negedge clk) begin
        bit run;
        if (chk_en) begin
            run = (ph >= 1 && ph <= 16);
            if (done === 1'b1) done_seen++;
            check("busy", int'(busy), int'(ph >= 1 && ph <= 17));
            check("done", int'(done), int'(ph == 18 || ph == -1));
            check("err", int'(err), int'(m_err));
            check("stage_en", int'(stage_en), int'(run));
            check("stage_shift_value", int'(stage_shift_value), run ? ph - 1 : 0);
            check("stage_shift_angle", int'(stage_shift_angle), run ? atan_ref[ph-1] : 0);
            check("stage_target", int'(stage_target), run ? m_tgt : 0);
            check("stage_x", int'(stage_x), !run ? 0 : (ph == 1) ? KINIT : int'(new_x));
            check("stage_y", int'(stage_y), (run && ph > 1) ? int'(new_y) : 0);
            check("stage_angle", int'(stage_angle), (run && ph > 1) ? int'(new_a) : 0);
            check("result_x", int'(result_x), m_rx);
            check("result_y", int'(result_y), m_ry);
            check("result_angle", int'(result_angle), m_ra);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rotate(input int tgt, input int wait_cycles);
        start     = 1'b1;
        target_in = DW'(tgt);
        step();
        start     = 1'b0;
        target_in = DW'($urandom);
        repeat (wait_cycles) step();
    endtask

    task automatic rotate_near(input int tgt, input int ex, input int ey);
        rotate(tgt, 20);
        check_near("acc_x", int'(result_x), ex);
        check_near("acc_y", int'(result_y), ey);
        check_near("acc_angle", int'(result_angle), tgt);
        check("acc_err", int'(err), 0);
    endtask

    initial begin
        int d0, rx, ry, ra, tgt, gap;
        for (int k = 0; k < NIT; k++)
            atan_ref[k] = $rtoi($atan(2.0 ** (-k)) * 1048576.0 + 0.5);
        check("model_atan0", atan_ref[0], 823550);
        check("model_atan15", atan_ref[15], 32);
        cordic_ref(0, rx, ry, ra);
        check_near("model_cos0", rx, ONE);
        check_near("model_sin0", ry, 0);

        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Accuracy at 0 and +/- pi/4.
        rotate_near(0, ONE, 0);
        rotate_near(823550, 741455, 741455);
        rotate_near(-823550, 741455, -741455);

        // Out-of-range boundary and just-in-range boundary.
        d0 = done_seen;
        rotate(ASUM + 1, 4);
        check("err_set", int'(err), 1);
        check("err_done_count", done_seen - d0, 1);
        rotate(ASUM, 20);
        check("boundary_pos_err", int'(err), 0);
        rotate(-ASUM, 20);
        rotate(-ASUM - 1, 3);

        // Start during RUN ignored; exactly one done.
        d0 = done_seen;
        start = 1'b1; target_in = DW'(400000); step();
        start = 1'b0; repeat (4) step();
        start = 1'b1; target_in = DW'(-100000); step();
        start = 1'b0; repeat (20) step();
        check("one_done", done_seen - d0, 1);

        // Reset mid-RUN: no done afterwards.
        d0 = done_seen;
        start = 1'b1; target_in = DW'(-300000); step();
        start = 1'b0; repeat (8) step();
        reset = 1'b1; step();
        reset = 1'b0; repeat (25) step();
        check("no_done_after_reset", done_seen - d0, 0);

        // Start held high: ignored in DONE, accepted in the following IDLE.
        d0 = done_seen;
        start = 1'b1; target_in = DW'(123456);
        repeat (40) step();
        start = 1'b0;
        repeat (20) step();
        check("held_start_dones", done_seen - d0, 3);

        // Randomized traffic with boundary bias, stray starts and occasional resets.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3) == 0)
                tgt = ASUM + int'($urandom_range(2)) - 1;
            else
                tgt = int'($urandom_range(4194303)) - 2097152;
            if ($urandom_range(1) == 0) tgt = -tgt;
            start = 1'b1; target_in = DW'(tgt); step();
            start = 1'b0;
            gap = int'($urandom_range(19, 1));
            repeat (gap) begin
                start = ($urandom_range(5) == 0);
                target_in = DW'($urandom);
                step();
            end
            start = 1'b0;
            if ($urandom_range(7) == 0) begin
                reset = 1'b1; step(); reset = 1'b0;
            end
            repeat (20 + int'($urandom_range(3))) step();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
